axi_sram_arbiter: RTL

//  Shares one single-port 32-bit SRAM between the AXI slave write channel and read channel.

---
 rtl/sram_arb_pkg.sv | 70 +++++++
 rtl/sram_lane_align.sv | 27 ++
 rtl/axi_sram_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types, constants and lane helpers for the AXI SRAM arbiter.
//   arb_state_e  : arbiter FSM states (IDLE, WR, RD)
//   chan_e       : channel identity used for round-robin bookkeeping
//   SIZE_B/H/W   : AxSIZE encodings for byte, halfword and word beats
//   rd_tag_t     : per-beat tag carried down the read-return pipe
//   be_gen       : byte enables for a beat of given size at addr[1:0]
//   lane_replicate : replicates right-justified write data across lanes
//   lane_extract : pulls a right-justified, zero-extended value out of a word
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } arb_state_e;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } chan_e;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    typedef struct packed {
        logic       valid;
        logic [1:0] addr_lo;
        logic [2:0] size;
    } rd_tag_t;

    // Halfwords always sit on an even lane pair, so addr[0] is dropped there.
    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << addr_lo;
            SIZE_H:  be = 4'b0011 << {addr_lo[1], 1'b0};
            SIZE_W:  be = 4'hF;
            default: be = 4'hF;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [2:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SIZE_B:  rep = {4{data[7:0]}};
            SIZE_H:  rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [2:0] size,
                                                 input logic [1:0] addr_lo);
        logic [31:0] shifted;
        logic [31:0] value;
        shifted = word >> {addr_lo, 3'b000};
        case (size)
            SIZE_B:  value = {24'h0, shifted[7:0]};
            SIZE_H:  value = {16'h0, shifted[15:0]};
            default: value = shifted;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/sram_lane_align.sv
// ---------------------------------------------------------------------------
// sram_lane_align
// Purely combinational lane steering between the AXI channels and the SRAM.
//   acc_size/acc_addr_lo/acc_wdata : beat being issued to the SRAM
//   acc_be/acc_wdata_rep           : byte enables and lane-replicated data
//   rd_size/rd_addr_lo/rd_word     : tag of the returning read and raw SRAM word
//   rd_data                        : right-justified, zero-extended read value
// ---------------------------------------------------------------------------
module sram_lane_align
    import sram_arb_pkg::*;
(
    input  logic [2:0]  acc_size,
    input  logic [1:0]  acc_addr_lo,
    input  logic [31:0] acc_wdata,
    output logic [3:0]  acc_be,
    output logic [31:0] acc_wdata_rep,
    input  logic [2:0]  rd_size,
    input  logic [1:0]  rd_addr_lo,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    assign acc_be        = be_gen(acc_size, acc_addr_lo);
    assign acc_wdata_rep = lane_replicate(acc_size, acc_wdata);
    assign rd_data       = lane_extract(rd_word, rd_size, rd_addr_lo);

endmodule

// File: rtl/axi_sram_arbiter.sv
// ---------------------------------------------------------------------------
// axi_sram_arbiter
// Shares one single-port 32-bit SRAM between the AXI write and read channels.
// The whole SRAM is granted to one channel per burst; ties alternate
// round-robin. SRAM strobes are registered; read data returns RD_LATENCY+1
// cycles after the beat is accepted.
//   ACLK, ARESET                       : clock, asynchronous active-high reset
//   w_req/w_en/w_last/w_size/w_addr/w_data : write channel beat interface
//   w_gnt                              : write channel owns the SRAM
//   r_req/r_en/r_last/r_size/r_addr    : read channel beat interface
//   r_gnt                              : read channel owns the SRAM
//   r_rvalid/r_rdata                   : returned read data
//   sram_cs/we/addr/be/wdata/rdata     : SRAM macro interface
// ---------------------------------------------------------------------------
module axi_sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  w_req,
    input  logic                  w_en,
    input  logic                  w_last,
    input  logic [2:0]            w_size,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_gnt,
    input  logic                  r_req,
    input  logic                  r_en,
    input  logic                  r_last,
    input  logic [2:0]            r_size,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_gnt,
    output logic                  r_rvalid,
    output logic [DATA_WIDTH-1:0] r_rdata,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-3:0] sram_addr,
    output logic [3:0]            sram_be,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    arb_state_e            state;
    arb_state_e            state_next;
    chan_e                 last_grant;
    chan_e                 last_grant_next;
    logic                  w_acc;
    logic                  r_acc;
    logic [2:0]            acc_size;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [3:0]            acc_be;
    logic [31:0]           acc_wdata_rep;
    rd_tag_t               rd_pipe [RD_LATENCY+1];
    rd_tag_t               rd_tail;
    logic [31:0]           rd_data;

    // Grants decode straight from the state register so they drop the
    // instant reset is applied.
    assign w_gnt = (state == WR);
    assign r_gnt = (state == RD);
    assign w_acc = w_gnt & w_en;
    assign r_acc = r_gnt & r_en;

    // Only one grant is ever active, so the accepted beat selects the lane source.
    assign acc_size = r_acc ? r_size : w_size;
    assign acc_addr = r_acc ? r_addr : w_addr;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            last_grant <= READ;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // A finishing burst hands over directly to a waiting channel so switching
    // costs no idle cycle; a request dropped without last aborts to IDLE.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (w_req && (!r_req || last_grant == READ)) begin
                    state_next = WR;
                end else if (r_req) begin
                    state_next = RD;
                end
            end
            WR: begin
                if (w_acc && w_last) begin
                    last_grant_next = WRITE;
                    state_next      = r_req ? RD : IDLE;
                end else if (!w_req) begin
                    state_next = IDLE;
                end
            end
            RD: begin
                if (r_acc && r_last) begin
                    last_grant_next = READ;
                    state_next      = w_req ? WR : IDLE;
                end else if (!r_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sram_lane_align u_lane_align (
        .acc_size      (acc_size),
        .acc_addr_lo   (acc_addr[1:0]),
        .acc_wdata     (w_data),
        .acc_be        (acc_be),
        .acc_wdata_rep (acc_wdata_rep),
        .rd_size       (rd_tail.size),
        .rd_addr_lo    (rd_tail.addr_lo),
        .rd_word       (sram_rdata),
        .rd_data       (rd_data)
    );

    // Address, enables and write data hold between accesses; the write data
    // register only moves on write beats.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_be    <= '0;
            sram_wdata <= '0;
        end else begin
            sram_cs <= w_acc | r_acc;
            if (w_acc | r_acc) begin
                sram_we   <= w_acc;
                sram_addr <= acc_addr[ADDR_WIDTH-1:2];
                sram_be   <= acc_be;
            end
            if (w_acc) begin
                sram_wdata <= acc_wdata_rep;
            end
        end
    end

    // The read-return pipe runs regardless of FSM state, so reads still in
    // flight when a write takes over complete normally.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_pipe[0] <= rd_tag_t'({r_acc, r_addr[1:0], r_size});
            for (int i = 1; i <= RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rd_tail  = rd_pipe[RD_LATENCY];
    assign r_rvalid = rd_tail.valid;
    assign r_rdata  = rd_tail.valid ? rd_data : '0;

endmodule
